// File: rtl/rst_s_mp.sv
// rst_s_mp: register scoreboard tracking a busy bit and producer tag per
// architectural register. Dispatch allocates, tagged writebacks release,
// flush clears the whole table. Lookups read the registered table.
// Optional feature macro: RST_S_WB_BYPASS_EN (lookups see same-cycle clears).
module rst_s_mp #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned TAG_W    = 4,
    parameter int unsigned NUM_WB   = 2,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned SEL_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    localparam int unsigned CNT_W   = $clog2(NUM_REGS + 1)
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      di_write,
    input  logic [SEL_W-1:0]          di_sel,
    input  logic [TAG_W-1:0]          di_tag,
    input  logic [NUM_WB-1:0]         wb_write,
    input  logic [NUM_WB*SEL_W-1:0]   wb_sel,
    input  logic [NUM_WB*TAG_W-1:0]   wb_tag,
    input  logic                      flush,
    input  logic [NUM_RD*SEL_W-1:0]   rd_sel,
    output logic [NUM_RD-1:0]         rd_busy,
    output logic [NUM_RD*TAG_W-1:0]   rd_tag,
    output logic [NUM_REGS-1:0]       busy_vec,
    output logic [CNT_W-1:0]          busy_cnt
);

    logic [NUM_REGS-1:0]            r_busy;
    logic [NUM_REGS-1:0][TAG_W-1:0] r_tag;
    logic [CNT_W-1:0]               r_cnt;

    logic [NUM_REGS-1:0]            w_clr;
    logic [NUM_REGS-1:0]            w_set;
    logic [NUM_REGS-1:0]            w_byp;
    logic [NUM_REGS-1:0]            w_busy_nxt;
    logic [NUM_REGS-1:0][TAG_W-1:0] w_tag_nxt;
    logic [CNT_W-1:0]               w_cnt_nxt;
    logic [SEL_W-1:0]               w_wb_sel [NUM_WB];
    logic [TAG_W-1:0]               w_wb_tag [NUM_WB];
    logic [SEL_W-1:0]               w_rd_sel [NUM_RD];

    // Unpack per-port writeback and lookup fields
    always_comb begin
        for (int k = 0; k < NUM_WB; k++) begin
            w_wb_sel[k] = wb_sel[k*SEL_W +: SEL_W];
            w_wb_tag[k] = wb_tag[k*TAG_W +: TAG_W];
        end
        for (int j = 0; j < NUM_RD; j++) begin
            w_rd_sel[j] = rd_sel[j*SEL_W +: SEL_W];
        end
    end

    // Per-entry release (tag-matching writeback) and allocate decode
    always_comb begin
        w_clr = '0;
        w_set = '0;
        for (int e = 0; e < NUM_REGS; e++) begin
            for (int k = 0; k < NUM_WB; k++) begin
                if (wb_write[k] && (w_wb_sel[k] == SEL_W'(e)) &&
                    r_busy[e] && (r_tag[e] == w_wb_tag[k])) begin
                    w_clr[e] = 1'b1;
                end
            end
            w_set[e] = di_write && (di_sel == SEL_W'(e)) &&
                       !((ZERO_REG != 0) && (e == 0));
        end
        // Clears that will actually take effect: dispatch and flush win
        w_byp = w_clr & ~w_set & {NUM_REGS{~flush}};
    end

    // Next table state: release, then allocate (dispatch wins), flush overrides
    always_comb begin
        w_busy_nxt = r_busy;
        w_tag_nxt  = r_tag;
        for (int e = 0; e < NUM_REGS; e++) begin
            if (w_clr[e]) begin
                w_busy_nxt[e] = 1'b0;
                w_tag_nxt[e]  = '0;
            end
            if (w_set[e]) begin
                w_busy_nxt[e] = 1'b1;
                w_tag_nxt[e]  = di_tag;
            end
        end
        if (flush) begin
            w_busy_nxt = '0;
            w_tag_nxt  = '0;
        end
    end

    // Popcount of the next busy vector so the registered count tracks busy_vec
    always_comb begin
        w_cnt_nxt = '0;
        for (int e = 0; e < NUM_REGS; e++) begin
            w_cnt_nxt = w_cnt_nxt + CNT_W'(w_busy_nxt[e]);
        end
    end

    // Table state registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_busy <= '0;
            r_tag  <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_tag  <= w_tag_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign busy_vec = r_busy;
    assign busy_cnt = r_cnt;

    // Zero-latency lookups; out-of-range selects read as idle
    always_comb begin
        rd_busy = '0;
        rd_tag  = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            if (32'(w_rd_sel[j]) < NUM_REGS) begin
`ifdef RST_S_WB_BYPASS_EN
                if (!w_byp[w_rd_sel[j]]) begin
                    rd_busy[j]               = r_busy[w_rd_sel[j]];
                    rd_tag[j*TAG_W +: TAG_W] = r_tag[w_rd_sel[j]];
                end
`else
                rd_busy[j]               = r_busy[w_rd_sel[j]];
                rd_tag[j*TAG_W +: TAG_W] = r_tag[w_rd_sel[j]];
`endif
            end
        end
    end

`ifndef RST_S_WB_BYPASS_EN
    // Effective-clear vector only feeds the lookup bypass
    logic w_byp_unused;
    assign w_byp_unused = ^w_byp;
`endif

endmodule

// File: tb/tb_rst_s_mp.sv
// Directed bench for rst_s_mp: stimulus pushes expected observations into a
// queue tagged with the cycle they apply to; a negedge monitor pops and checks.
module tb_rst_s_mp;

`ifdef RST_S_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        di_write;
    logic [4:0]  di_sel;
    logic [3:0]  di_tag;
    logic [1:0]  wb_write;
    logic [9:0]  wb_sel;
    logic [7:0]  wb_tag;
    logic        flush;
    logic [9:0]  rd_sel;
    logic [1:0]  rd_busy;
    logic [7:0]  rd_tag;
    logic [31:0] busy_vec;
    logic [5:0]  busy_cnt;

    rst_s_mp dut (
        .CLK      (clk),
        .RST      (rst),
        .di_write (di_write),
        .di_sel   (di_sel),
        .di_tag   (di_tag),
        .wb_write (wb_write),
        .wb_sel   (wb_sel),
        .wb_tag   (wb_tag),
        .flush    (flush),
        .rd_sel   (rd_sel),
        .rd_busy  (rd_busy),
        .rd_tag   (rd_tag),
        .busy_vec (busy_vec),
        .busy_cnt (busy_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int          cyc;
        logic [1:0]  busy;
        logic [7:0]  tag;
        logic [5:0]  cnt;
        logic [31:0] vec;
    } exp_t;

    exp_t  q_exp  [$];
    string q_name [$];
    int    cyc    = 0;
    int    checks = 0;
    int    errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string nm, input string fld,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s got 0x%0h expected 0x%0h", nm, fld, act, exp);
        end
    endtask

    // Monitor: check every expectation stamped for the current cycle
    always @(negedge clk) begin
        while (q_exp.size() > 0 && q_exp[0].cyc <= cyc) begin
            exp_t  e;
            string n;
            e = q_exp.pop_front();
            n = q_name.pop_front();
            if (e.cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s missed got cycle %0d expected cycle %0d", n, cyc, e.cyc);
            end else begin
                cmp(n, "rd_busy",  32'(rd_busy),  32'(e.busy));
                cmp(n, "rd_tag",   32'(rd_tag),   32'(e.tag));
                cmp(n, "busy_cnt", 32'(busy_cnt), 32'(e.cnt));
                cmp(n, "busy_vec", busy_vec,      e.vec);
            end
        end
    end

    task automatic expect_now(input string nm, input logic b0, input logic [3:0] t0,
                              input logic b1, input logic [3:0] t1,
                              input int c, input logic [31:0] v);
        exp_t e;
        e.cyc  = cyc;
        e.busy = {b1, b0};
        e.tag  = {t1, t0};
        e.cnt  = 6'(c);
        e.vec  = v;
        q_exp.push_back(e);
        q_name.push_back(nm);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        di_write = 1'b0;
        wb_write = 2'b00;
        flush    = 1'b0;
        rst      = 1'b0;
    endtask

    task automatic dispatch(input logic [4:0] s, input logic [3:0] t);
        di_write = 1'b1;
        di_sel   = s;
        di_tag   = t;
    endtask

    task automatic wb(input int p, input logic [4:0] s, input logic [3:0] t);
        wb_write[p]      = 1'b1;
        wb_sel[p*5 +: 5] = s;
        wb_tag[p*4 +: 4] = t;
    endtask

    task automatic rd(input logic [4:0] s0, input logic [4:0] s1);
        rd_sel = {s1, s0};
    endtask

    initial begin
        rst = 1'b1; di_write = 1'b0; di_sel = '0; di_tag = '0;
        wb_write = '0; wb_sel = '0; wb_tag = '0; flush = 1'b0; rd_sel = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state, then allocate entry 5 tag 3
        rd(5, 0); dispatch(5, 3);
        expect_now("reset", 0, 0, 0, 0, 0, 32'h0);
        step();
        // Allocation visible; stale writeback (tag 2) on port 0
        rd(5, 0); wb(0, 5, 2);
        expect_now("alloc", 1, 3, 0, 0, 1, 32'h20);
        step();
        // Matching writeback on port 1 (bypass hides entry this cycle)
        rd(5, 0); wb(1, 5, 3);
        expect_now("stale_wb", !BYP, BYP ? 4'd0 : 4'd3, 0, 0, 1, 32'h20);
        step();
        // Released; allocate entry 7 tag 1
        rd(5, 7); dispatch(7, 1);
        expect_now("wb_clear", 0, 0, 0, 0, 0, 32'h0);
        step();
        // Same-cycle dispatch (tag 9) and matching writeback to entry 7
        rd(7, 7); dispatch(7, 9); wb(0, 7, 1);
        expect_now("pre_redisp", 1, 1, 1, 1, 1, 32'h80);
        step();
        rd(7, 9); dispatch(1, 2);
        expect_now("disp_wins", 1, 9, 0, 0, 1, 32'h80);
        step();
        rd(1, 7); dispatch(2, 3);
        expect_now("fill1", 1, 2, 1, 9, 2, 32'h82);
        step();
        rd(2, 3); dispatch(3, 4);
        expect_now("fill2", 1, 3, 0, 0, 3, 32'h86);
        step();
        // Flush overrides a dispatch and a matching writeback
        rd(3, 4); flush = 1'b1; dispatch(4, 5); wb(1, 1, 2);
        expect_now("pre_flush", 1, 4, 0, 0, 4, 32'h8E);
        step();
        // Dispatch to register 0 is dropped
        rd(4, 1); dispatch(0, 6);
        expect_now("flush", 0, 0, 0, 0, 0, 32'h0);
        step();
        rd(0, 0); dispatch(9, 4);
        expect_now("zero_reg", 0, 0, 0, 0, 0, 32'h0);
        step();
        // Writeback lookup same cycle: bypass-dependent
        rd(9, 9); wb(0, 9, 4);
        expect_now("bypass", !BYP, BYP ? 4'd0 : 4'd4, !BYP, BYP ? 4'd0 : 4'd4, 1, 32'h200);
        step();
        rd(9, 9); dispatch(10, 7);
        expect_now("bypass_next", 0, 0, 0, 0, 0, 32'h0);
        step();
        rd(10, 11); dispatch(11, 8);
        expect_now("alloc10", 1, 7, 0, 0, 1, 32'h400);
        step();
        // Two ports hit entry 11: port 0 stale, port 1 matches
        rd(10, 11); wb(0, 11, 3); wb(1, 11, 8);
        expect_now("multi_wb", 1, 7, !BYP, BYP ? 4'd0 : 4'd8, 2, 32'hC00);
        step();
        // Reset overrides a pending dispatch
        rd(10, 11); rst = 1'b1; dispatch(12, 2);
        expect_now("pre_rst", 1, 7, 0, 0, 1, 32'h400);
        step();
        rd(12, 13); dispatch(13, 1);
        expect_now("mid_rst", 0, 0, 0, 0, 0, 32'h0);
        step();
        rd(12, 13);
        expect_now("post_rst", 0, 0, 1, 1, 1, 32'h2000);
        step();

        // Drain: every expectation must be consumed within a bounded window
        for (int i = 0; i < 10 && q_exp.size() > 0; i++) @(negedge clk);
        if (q_exp.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain got %0d pending expected 0", q_exp.size());
        end
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rst_s_mp.md
RST_S_MP -- requirements
Module: rst_s_mp

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, number of tracked architectural registers.
REQ-002 SHALL have parameter TAG_W, default 4, producer tag width.
REQ-003 SHALL have parameter NUM_WB, default 2, number of writeback ports.
REQ-004 SHALL have parameter NUM_RD, default 2, number of lookup ports.
REQ-005 SHALL have parameter ZERO_REG, default 1; 1 means register 0 is never busy.
REQ-006 SHALL have ports (SEL_W = clog2(NUM_REGS)):
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset; synchronous, active-high.
- di_write  in  1  dispatch allocate strobe.
- di_sel  in  SEL_W  destination register being allocated.
- di_tag  in  TAG_W  producer tag for allocation.
- wb_write  in  NUM_WB  per-port writeback strobe.
- wb_sel  in  NUM_WB x SEL_W  per-port writeback register.
- wb_tag  in  NUM_WB x TAG_W  per-port writeback producer tag.
- flush  in  1  clear entire table.
- rd_sel  in  NUM_RD x SEL_W  per-port lookup register.
- rd_busy  out  NUM_RD  lookup result busy.
- rd_tag  out  NUM_RD x TAG_W  lookup result tag.
- busy_vec  out  NUM_REGS  registered busy bit per entry.
- busy_cnt  out  clog2(NUM_REGS+1)  registered count of busy entries.

Function
REQ-007 SHALL hold per entry a busy bit and a TAG_W tag, updated only on rising CLK.
REQ-008 Writeback port k SHALL clear entry wb_sel[k] (busy=0, tag=0) only if wb_write[k]=1, entry busy=1, and stored tag equals wb_tag[k]; otherwise no effect (stale writeback ignored).
REQ-009 Multiple writeback ports targeting one entry in a cycle SHALL clear it if any port matches; non-matching ports have no effect.
REQ-010 Dispatch SHALL set entry di_sel to busy=1, tag=di_tag on the next edge, regardless of prior busy state (re-allocation overwrites tag).
REQ-011 Same-cycle dispatch and matching writeback to the same entry: dispatch SHALL win (entry ends busy with di_tag).
REQ-012 With ZERO_REG=1, dispatch to register 0 SHALL be ignored; entry 0 SHALL read busy=0, tag=0 at all times.
REQ-013 flush=1 SHALL clear all entries on the next edge and SHALL override di_write and wb_write in the same cycle.
REQ-014 rd_busy/rd_tag SHALL be combinational from registered table state for rd_sel; zero latency.
REQ-015 busy_vec SHALL equal the registered busy bits; busy_cnt SHALL equal popcount(busy_vec) every cycle, including after multi-port updates.
REQ-016 Out-of-range sel values (>= NUM_REGS) SHALL be ignored for writes; lookups SHALL return busy=0, tag=0.

Reset
REQ-017 RST=1 at a rising edge SHALL clear all busy bits and tags, busy_vec=0, busy_cnt=0; RST overrides flush, dispatch and writeback.
REQ-018 Reset mid-operation SHALL discard all pending allocations; first post-reset cycle accepts dispatch normally.

Configuration
REQ-019 Macro RST_S_WB_BYPASS_EN SHALL compile in lookup bypass: if a writeback in the current cycle would clear rd_sel's entry (REQ-008 match, no same-cycle dispatch to it, no flush), rd_busy=0 and rd_tag=0 immediately.
REQ-020 Without RST_S_WB_BYPASS_EN, lookups SHALL reflect registered state only; a clearing writeback becomes visible one cycle later.

Verification
REQ-021 Reset, then di_write sel=5 tag=3 -> next cycle rd_sel=5 gives busy=1 tag=3, busy_cnt=1, busy_vec[5]=1.
REQ-022 Entry 5 busy tag=3; wb port0 sel=5 tag=2 -> entry stays busy tag=3; then wb port1 sel=5 tag=3 -> busy=0, busy_cnt=0.
REQ-023 Entry 7 busy tag=1; same cycle wb sel=7 tag=1 and di_write sel=7 tag=9 -> entry busy tag=9, busy_cnt unchanged.
REQ-024 Entries 1,2,3 busy; flush with di_write sel=4 tag=5 -> all clear, busy_cnt=0, entry 4 not busy.
REQ-025 di_write sel=0 tag=6 with ZERO_REG=1 -> rd_busy=0, busy_cnt=0.
REQ-026 Entry 9 busy tag=4; wb sel=9 tag=4 with rd_sel=9 same cycle -> rd_busy=0 that cycle with RST_S_WB_BYPASS_EN, rd_busy=1 without; both 0 next cycle.
